shift_issue_stage: RTL and testbench

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

---
 rtl/shift_issue_stage.sv | 210 +++++++++++++++++++++
 tb/tb_shift_issue_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Issue buffer that sits between decode and the barrel shifter. It accepts
// shift operations (LSH / RSH / ARSH) and conditions the operands into the
// form the shifter expects, using the ALU32/ALU64 semantics:
//   - ALU64 : a passes through, shift amount masked to 6 bits
//   - ALU32 : a narrowed to 32 bits (sign-extended for ARSH, zero-extended
//             otherwise), shift amount masked to 5 bits
// The conditioned operands are stored in a small in-order FIFO, so the
// shifter never sees raw operands. Illegal opcodes (2'b11) still complete
// the handshake, but they are dropped and raise a sticky flag.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   CNT_W        width of the delivered-operation counter
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   flush        synchronous flush, drops every buffered entry
//   in_valid     upstream has an operation
//   in_ready     stage can accept (never depends on out_ready)
//   in_op        00 LSH, 01 RSH, 10 ARSH, 11 illegal
//   in_is64      1 = ALU64, 0 = ALU32
//   in_dst       destination register index
//   in_a, in_b   raw value and raw shift amount
//   out_valid    head entry available
//   out_ready    downstream accepts the head entry
//   out_op, out_is64, out_dst   passed through from the push
//   out_a, out_b conditioned operands
//   illegal_op   sticky: an illegal opcode was accepted
//   issue_count  number of output transfers, wraps
// -----------------------------------------------------------------------------
module shift_issue_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_is64,
    input  logic [3:0]       in_dst,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_op,
    output logic             out_is64,
    output logic [3:0]       out_dst,
    output logic [63:0]      out_a,
    output logic [63:0]      out_b,

    output logic             illegal_op,
    output logic [CNT_W-1:0] issue_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [1:0] OP_ARSH = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic        is64;
        logic [3:0]  dst;
        logic [63:0] a;
        logic [63:0] b;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           push_entry;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // in_ready only looks at local state and the rst/flush inputs; a pop in
    // the same cycle does not open a slot until the next cycle.
    assign in_ready  = !rst && !flush && (occ_q != OCC_FULL);
    assign out_valid = (occ_q != '0);

    assign accept = in_valid && in_ready;
    // Illegal ops complete the handshake but never enter the FIFO.
    assign push   = accept && (in_op != OP_ILL);
    assign pop    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Operand conditioning, done before the FIFO write
    // ------------------------------------------------------------------
    always_comb begin
        push_entry      = '0;
        push_entry.op   = in_op;
        push_entry.is64 = in_is64;
        push_entry.dst  = in_dst;

        // Masking the full word keeps every bit of in_b in the expression.
        push_entry.b    = in_b & (in_is64 ? 64'd63 : 64'd31);

        if (in_is64) begin
            push_entry.a = in_a;
        end else if (in_op == OP_ARSH) begin
            push_entry.a = {{32{in_a[31]}}, in_a[31:0]};
        end else begin
            push_entry.a = {32'd0, in_a[31:0]};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        illegal_d = illegal_q | (accept && (in_op == OP_ILL));
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, pop};

        if (flush) begin
            // A pop on the flush edge still counts (cnt_d above); any push
            // is impossible because in_ready is low while flush is high.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    occ_d    = occ_q + OCC_ONE;
                end
                2'b01: begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    occ_d    = occ_q - OCC_ONE;
                end
                2'b11: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage is cleared on reset so the outputs read zero until the first
    // push lands; after that, an empty FIFO shows stale head data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head entry comes straight from storage: there is no bypass, so a
    // pushed entry is visible the cycle after its push edge, and stays
    // stable while stalled because rd_ptr_q only moves on a pop.
    assign out_op      = mem_q[rd_ptr_q].op;
    assign out_is64    = mem_q[rd_ptr_q].is64;
    assign out_dst     = mem_q[rd_ptr_q].dst;
    assign out_a       = mem_q[rd_ptr_q].a;
    assign out_b       = mem_q[rd_ptr_q].b;

    assign illegal_op  = illegal_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Bench for shift_issue_stage. A queue-based reference model holds the
// conditioned operations in order; every cycle the DUT's handshake signals,
// flags, counter and head data are compared with the model, then the model
// advances from the handshakes it predicts. Directed sequences cover the
// worked examples, followed by a long randomized run. A narrow counter is used
// so that issue_count wraps during the run.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_is64;
    logic [3:0]       in_dst;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_op;
    logic             out_is64;
    logic [3:0]       out_dst;
    logic [63:0]      out_a;
    logic [63:0]      out_b;
    logic             illegal_op;
    logic [CNT_W-1:0] issue_count;

    shift_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_is64     (in_is64),
        .in_dst      (in_dst),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_is64    (out_is64),
        .out_dst     (out_dst),
        .out_a       (out_a),
        .out_b       (out_b),
        .illegal_op  (illegal_op),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic        is64;
        logic [3:0]  dst;
        logic [63:0] a;
        logic [63:0] b;
    } ent_t;

    ent_t q[$];
    bit   m_ill;
    int   m_cnt;
    bit   m_pushed;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Operand rules expressed arithmetically: shift amount modulo the
    // operand width, 32-bit value reinterpreted as signed or unsigned.
    function automatic ent_t cond(input logic [1:0] op, input logic w64,
                                  input logic [3:0] d, input logic [63:0] a,
                                  input logic [63:0] b);
        ent_t e;
        int   s32;
        e.op   = op;
        e.is64 = w64;
        e.dst  = d;
        if (w64) begin
            e.a = a;
            e.b = b % 64;
        end else begin
            e.b = b % 32;
            if (op == 2'b10) begin
                s32 = int'(a[31:0]);
                e.a = 64'(s32);
            end else begin
                e.a = 64'(a % 64'h1_0000_0000);
            end
        end
        return e;
    endfunction

    // One clock cycle: drive, compare against the model mid-cycle, then
    // advance the model across the rising edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [1:0] op, input logic w64, input logic [3:0] d,
                        input logic [63:0] a, input logic [63:0] b, input logic ordy);
        bit   er;
        bit   ev;
        ent_t e;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_op     = op;
        in_is64   = w64;
        in_dst    = d;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #3;
        er = !r && !f && (q.size() < DEPTH);
        ev = (q.size() > 0);
        check("in_ready",    64'(in_ready),    64'(er));
        check("out_valid",   64'(out_valid),   64'(ev));
        check("illegal_op",  64'(illegal_op),  64'(m_ill));
        check("issue_count", 64'(issue_count), 64'(m_cnt));
        if (ev) begin
            e = q[0];
            check("out_ctl", 64'({out_op, out_is64, out_dst}), 64'({e.op, e.is64, e.dst}));
            check("out_a",   out_a, e.a);
            check("out_b",   out_b, e.b);
        end else if (!m_pushed) begin
            check("out_ctl_rst", 64'({out_op, out_is64, out_dst}), 64'd0);
            check("out_a_rst",   out_a, 64'd0);
            check("out_b_rst",   out_b, 64'd0);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ill    = 1'b0;
            m_cnt    = 0;
            m_pushed = 1'b0;
        end else begin
            if (ev && ordy) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % CNT_MOD;
            end
            if (f) begin
                q.delete();
            end else if (iv && er) begin
                if (op == 2'b11) begin
                    m_ill = 1'b1;
                end else begin
                    q.push_back(cond(op, w64, d, a, b));
                    m_pushed = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 64'd0, ordy);
    endtask

    task automatic push(input logic [1:0] op, input logic w64, input logic [3:0] d,
                        input logic [63:0] a, input logic [63:0] b, input logic ordy);
        step(1'b0, 1'b0, 1'b1, op, w64, d, a, b, ordy);
    endtask

    initial begin
        int c0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_is64 = 1'b0;
        in_dst = 4'd0; in_a = 64'd0; in_b = 64'd0; out_ready = 1'b0;
        m_ill = 1'b0; m_cnt = 0; m_pushed = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for two cycles, flush asserted alongside must not matter.
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 4'd1, 64'd5, 64'd1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 4'd1, 64'd5, 64'd1, 1'b1);

        // ALU32 ARSH worked example.
        push(2'b10, 1'b0, 4'd3, 64'h0000_0000_8000_0010, 64'h24, 1'b1);
        check("ex1_valid", 64'(out_valid), 64'd1);
        check("ex1_a", out_a, 64'hFFFF_FFFF_8000_0010);
        check("ex1_b", out_b, 64'd4);
        idle(1'b1);
        check("ex1_cnt", 64'(issue_count), 64'd1);

        // ALU64 RSH, then ALU32 LSH zero-extension.
        push(2'b01, 1'b1, 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF41, 1'b0);
        check("ex2_a", out_a, 64'h8000_0000_0000_0000);
        check("ex2_b", out_b, 64'd1);
        push(2'b00, 1'b0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 1'b1);
        check("ex3_a", out_a, 64'h0000_0000_FFFF_FFFF);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: three pushes against a stalled output.
        push(2'b00, 1'b1, 4'd5, 64'h1111, 64'd1, 1'b0);
        push(2'b01, 1'b1, 4'd6, 64'h2222, 64'd2, 1'b0);
        check("bp_full", 64'(in_ready), 64'd0);
        push(2'b10, 1'b1, 4'd7, 64'h3333, 64'd3, 1'b0);
        push(2'b10, 1'b1, 4'd7, 64'h3333, 64'd3, 1'b0);
        push(2'b10, 1'b1, 4'd7, 64'h3333, 64'd3, 1'b1);
        push(2'b10, 1'b1, 4'd7, 64'h3333, 64'd3, 1'b1);
        check("bp_third", out_a, 64'h3333);
        idle(1'b1);
        idle(1'b1);

        // Steady push+pop at occupancy 1 for ten cycles.
        push(2'b00, 1'b1, 4'd8, 64'hA0, 64'd0, 1'b0);
        c0 = m_cnt;
        for (int i = 0; i < 10; i++) begin
            push(2'b01, 1'b0, 4'd9, 64'(i * 3 + 1), 64'(i), 1'b1);
        end
        check("pp_valid", 64'(out_valid), 64'd1);
        check("pp_cnt", 64'(issue_count), 64'((c0 + 10) % CNT_MOD));
        idle(1'b1);
        idle(1'b1);

        // Illegal opcode is swallowed; flush leaves the flag set.
        push(2'b11, 1'b1, 4'd1, 64'd9, 64'd9, 1'b1);
        check("ill_flag", 64'(illegal_op), 64'd1);
        check("ill_novalid", 64'(out_valid), 64'd0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1);
        check("ill_after_flush", 64'(illegal_op), 64'd1);

        // Reset with two entries buffered.
        push(2'b00, 1'b0, 4'd2, 64'h55, 64'd7, 1'b0);
        push(2'b01, 1'b0, 4'd3, 64'h66, 64'd8, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 64'd1, 64'd1, 1'b1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_cnt", 64'(issue_count), 64'd0);

        // Flush with two entries buffered.
        push(2'b10, 1'b0, 4'd2, 64'h8000_0000, 64'd40, 1'b0);
        push(2'b10, 1'b1, 4'd3, 64'h77, 64'd70, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 64'd1, 64'd1, 1'b0);
        check("flush_valid", 64'(out_valid), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        f;
            logic        iv;
            logic [1:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 39) == 0);
            iv = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom};
            step(r, f, iv, op, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)),
                 a, b, ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
